// File: rtl/bin2bcd_disp_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD display converter.
package bin2bcd_disp_pkg;

    localparam int DEF_BIN_W  = 27;
    localparam int DEF_DIGITS = 8;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned BCD_MAX = pow10(DEF_DIGITS) - 64'd1;
    localparam int CNT_W = $clog2(DEF_BIN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_disp.sv
// Sequential shift-and-add-3 binary to packed BCD converter for the scan driver.
module bin2bcd_disp
    import bin2bcd_disp_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CW    = $clog2(BIN_W);
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t             state_q;
    state_t             state_d;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   scr_q;
    logic [CW-1:0]      cnt_q;
    logic               ovf_q;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scr_nxt;
    logic               carry_unused;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Carry out of the top digit is dropped; overflow comes from the input compare.
    assign {carry_unused, scr_nxt} = {adj, bin_q[BIN_W-1]};

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs load on the last shift edge so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q <= bin_in;
                        scr_q <= '0;
                        cnt_q <= CW'(BIN_W - 1);
                        ovf_q <= (64'(bin_in) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    scr_q <= scr_nxt;
                    bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        bcd_out  <= ovf_q ? ALL_NINES : scr_nxt;
                        overflow <= ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Directed plus randomized checks of bin2bcd_disp against a decimal reference model.
module tb_bin2bcd_disp;

    logic        clk;
    logic        reset;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd_out;

    int tests = 0;
    int fails = 0;

    bin2bcd_disp dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] model(input logic [26:0] v);
        logic [31:0] r;
        int unsigned x;
        x = 32'(v);
        r = '0;
        if (x > 99999999) return 32'h9999_9999;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // From a negedge at cycle c0, wait for done; lat = cycle in which done is seen.
    task automatic wait_done(input int c0, output int lat);
        int bad_busy;
        lat = c0;
        bad_busy = 0;
        while (!done && lat < 40) begin
            if (!busy) bad_busy = 1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("busy_during", 32'(bad_busy), 32'd0);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic conv(input logic [26:0] v, input string tag);
        int lat;
        logic [26:0] junk;
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        junk   = 27'($urandom);
        bin_in = junk;
        wait_done(1, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd28);
        chk({tag, "_bcd"}, bcd_out, model(v));
        chk({tag, "_ovf"}, {31'd0, overflow},
            {31'd0, (32'(v) > 99999999)});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        int lat;
        int nd;
        logic [26:0] v;
        logic [26:0] hold_v;

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_bcd", bcd_out, 32'h0);
        reset = 1'b0;

        conv(27'd12345678, "t2");

        conv(27'd0, "t3a");
        conv(27'd99999999, "t3b");

        conv(27'd100000000, "t4a");
        conv(27'd42, "t4b");

        // Hold: bcd_out stays put while idle and bin_in wanders.
        repeat (5) begin
            @(negedge clk);
            bin_in = 27'($urandom);
        end
        chk("hold_bcd", bcd_out, 32'h0000_0042);

        // Start during conversion is ignored.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd555;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd777;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, lat);
        chk("t5_lat", 32'(lat), 32'd28);
        chk("t5_bcd", bcd_out, 32'h0000_0555);
        count_dones(40, nd);
        chk("t5_single_done", 32'(nd), 32'd0);

        // Reset mid-conversion discards the work.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd9876;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_bcd", bcd_out, 32'h0);
        count_dones(40, nd);
        chk("t6_no_done", 32'(nd), 32'd0);
        conv(27'd9876, "t6b");

        // Start together with reset is ignored.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        bin_in = 27'd31;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_bcd", bcd_out, 32'h0);

        conv(27'd134217727, "max_in");
        conv(27'd1, "one");
        conv(27'd10000000, "pow7");

        for (int i = 0; i < 12; i++) begin
            v = 27'($urandom_range(0, 99999999));
            conv(v, "rnd_lo");
        end
        for (int i = 0; i < 6; i++) begin
            v = 27'($urandom);
            conv(v, "rnd_full");
        end
        hold_v = v;
        repeat (3) @(negedge clk);
        chk("hold_final", bcd_out, model(hold_v));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
